redmule_tcdm_splitter: RTL
==========================

REDMULE_TCDM_SPLITTER -- requirements
Module: redmule_tcdm_splitter

Interface
REQ-001 SHALL have exactly one clock and a synchronous, active-high reset.
REQ-002 SHALL have parameter DW, default 288: wide-side data width in bits.
REQ-003 SHALL have parameter MP, default 9: narrow port count; DW%(MP*32)==0 is an elaboration check.
REQ-004 SHALL have parameter AW, default 32: address width.
REQ-005 SHALL have parameter RESP_DEPTH, default 2: maximum outstanding wide transactions, >=1.
REQ-006 SHALL have ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- in_req_i  in  1  wide request
- in_gnt_o  out  1  wide grant
- in_add_i  in  AW  wide byte address
- in_wen_i  in  1  1=read, 0=write
- in_be_i  in  DW/8  byte enables
- in_data_i  in  DW  write data
- in_r_data_o  out  DW  read data
- in_r_valid_o  out  1  response valid
- out_req_o  out  MP  narrow requests
- out_gnt_i  in  MP  narrow grants
- out_add_o  out  MP*AW  narrow addresses
- out_wen_o  out  MP  narrow wen
- out_be_o  out  MP*DW/(MP*8)  narrow byte enables
- out_data_o  out  MP*DW/MP  narrow write data
- out_r_data_i  in  MP*DW/MP  narrow read data
- out_r_valid_i  in  MP  narrow response valid
- busy_o  out  1  outstanding transactions or partial grant present
- err_o  out  1  sticky response-overflow flag

Function
REQ-007 Narrow port ii SHALL carry address in_add_i + ii*(DW/MP/8), slice ii of be/data, and in_wen_i.
REQ-008 A per-port grant mask gmask[MP-1:0] SHALL record ports already granted for the current wide request.
REQ-009 out_req_o[ii] SHALL equal in_req_i & ~gmask[ii] & credit_ok, where credit_ok = (outstanding<RESP_DEPTH) | (gmask!=0).
REQ-010 gmask[ii] SHALL set on out_req_o[ii]&out_gnt_i[ii]; the upstream holds request fields stable until in_gnt_o.
REQ-011 in_gnt_o SHALL assert combinationally in the cycle where gmask | (out_gnt_i&out_req_o) is all-ones; gmask SHALL clear in that same cycle.
REQ-012 Ports SHALL be grantable in different cycles; skewed grants SHALL never produce a duplicate narrow request.
REQ-013 Every granted wide transaction, read or write, SHALL yield exactly one out_r_valid_i pulse per port.
REQ-014 Each port SHALL own a RESP_DEPTH-deep response FIFO, pushed on out_r_valid_i[ii].
REQ-015 in_r_valid_o SHALL assert, registered, when all MP FIFOs are non-empty; all MP FIFOs SHALL pop in that cycle; in_r_data_o = concatenation of the FIFO heads, port 0 in the LSBs.
REQ-016 Latency: in_r_valid_o SHALL assert 1 cycle after the last port's response push, given no earlier pending responses.
REQ-017 The outstanding counter SHALL increment on in_gnt_o, decrement on in_r_valid_o, and stay unchanged when both occur in the same cycle.
REQ-018 At outstanding==RESP_DEPTH with gmask==0, all out_req_o SHALL be 0 and in_gnt_o SHALL be 0.
REQ-019 A push into a full FIFO SHALL drop the data and set err_o until reset.
REQ-020 busy_o SHALL equal (outstanding!=0) | (gmask!=0).
REQ-021 A response SHALL be pushable and poppable in the same cycle on a full FIFO without asserting err_o.

Reset
REQ-022 On rst_i, regardless of traffic in flight, gmask, counter, FIFOs, in_r_valid_o, and err_o SHALL clear; all outputs SHALL read 0 after reset, except pass-through narrow fields, which follow the inputs; late narrow responses received after reset SHALL assert err_o.

Structure
REQ-023 redmule_pkg SHALL hold the outstanding-counter width function and the narrow-slice-width constant derivation.
REQ-024 The per-port FIFO SHALL be sub-module redmule_split_fifo (synchronous active-high reset, depth parameter), instantiated MP times.

Verification (DW=128, MP=4, RESP_DEPTH=2)
REQ-025 All gnt same cycle, read at 0x1000 -> out_add_o = 0x1000/0x1004/0x1008/0x100C, in_gnt_o in the same cycle, responses pushed at t -> in_r_valid_o at t+1 with correct concatenation.
REQ-026 Port 2 granted 3 cycles late -> out_req_o[0,1,3] drop after 1 cycle, out_req_o[2] held, exactly one in_gnt_o.
REQ-027 Three back-to-back reads, responses withheld -> third request produces out_req_o=0 until the first in_r_valid_o.
REQ-028 Skewed responses (port 3 two cycles late) -> in_r_valid_o exactly once, one cycle after port 3's response.
REQ-029 in_gnt_o and in_r_valid_o in the same cycle -> outstanding unchanged; busy_o drops after the final response.
REQ-030 rst_i mid-transaction, then an extra out_r_valid_i -> outputs cleared; err_o=1 after a third pulse overflows a depth-2 FIFO.

Source files
------------

// File: rtl/redmule_pkg.sv
// Shared sizing helpers for the RedMulE TCDM splitter and its response FIFOs.
package redmule_pkg;

  localparam int unsigned WORD_W = 32;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  function automatic int unsigned slice_width(input int unsigned dw, input int unsigned mp);
    return dw / mp;
  endfunction

endpackage

// File: rtl/redmule_split_fifo.sv
// Per-port response FIFO; overflow_o pulses when a push finds no room and is dropped.
module redmule_split_fifo
  import redmule_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic          empty_o,
  output logic [DW-1:0] head_o,
  output logic          overflow_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, do_pop, do_wr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full       = (count == CW'(DEPTH));
  assign empty_o    = (count == '0);
  assign do_pop     = pop_i & ~empty_o;
  // A push that meets a pop on an empty FIFO is consumed directly by the reader.
  assign do_wr      = push_i & ~(pop_i & empty_o) & (~full | do_pop);
  assign overflow_o = push_i & full & ~do_pop;
  assign head_o     = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr)  wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_wr) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/redmule_tcdm_splitter.sv
// Splits one wide TCDM request into MP narrow requests with skew-tolerant grants,
// and reassembles the narrow responses into one wide response.
module redmule_tcdm_splitter
  import redmule_pkg::*;
#(
  parameter int unsigned DW         = 288,
  parameter int unsigned MP         = 9,
  parameter int unsigned AW         = 32,
  parameter int unsigned RESP_DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_req_i,
  output logic                   in_gnt_o,
  input  logic [AW-1:0]          in_add_i,
  input  logic                   in_wen_i,
  input  logic [DW/8-1:0]        in_be_i,
  input  logic [DW-1:0]          in_data_i,
  output logic [DW-1:0]          in_r_data_o,
  output logic                   in_r_valid_o,
  output logic [MP-1:0]          out_req_o,
  input  logic [MP-1:0]          out_gnt_i,
  output logic [MP*AW-1:0]       out_add_o,
  output logic [MP-1:0]          out_wen_o,
  output logic [MP*DW/(MP*8)-1:0] out_be_o,
  output logic [MP*DW/MP-1:0]    out_data_o,
  input  logic [MP*DW/MP-1:0]    out_r_data_i,
  input  logic [MP-1:0]          out_r_valid_i,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int unsigned SW = slice_width(DW, MP);
  localparam int unsigned BW = SW / 8;
  localparam int unsigned CW = cnt_width(RESP_DEPTH);

  if (((DW % (MP * WORD_W)) != 0) || (RESP_DEPTH < 1)) begin : g_param_check
    $error("redmule_tcdm_splitter: DW must be a multiple of MP*32 and RESP_DEPTH >= 1");
  end

  logic [MP-1:0] gmask, hit, empty, ovf, avail;
  logic [CW-1:0] outstanding;
  logic          credit_ok, fire;
  logic [DW-1:0] resp_data;
  logic          r_valid_p1;
  logic [DW-1:0] r_data_p1;

  // Credit is checked only when a new wide request starts; a partially granted one must finish.
  assign credit_ok = (outstanding < CW'(RESP_DEPTH)) | (|gmask);
  assign out_req_o = {MP{in_req_i & credit_ok}} & ~gmask;
  assign hit       = out_req_o & out_gnt_i;
  assign in_gnt_o  = in_req_i & (&(gmask | hit));
  assign busy_o    = (outstanding != '0) | (|gmask);

  assign avail = ~empty | out_r_valid_i;
  assign fire  = &avail;

  for (genvar ii = 0; ii < MP; ii++) begin : g_port
    logic [SW-1:0] head;

    assign out_add_o[ii*AW +: AW]  = in_add_i + AW'(ii * BW);
    assign out_wen_o[ii]           = in_wen_i;
    assign out_be_o[ii*BW +: BW]   = in_be_i[ii*BW +: BW];
    assign out_data_o[ii*SW +: SW] = in_data_i[ii*SW +: SW];
    assign resp_data[ii*SW +: SW]  = empty[ii] ? out_r_data_i[ii*SW +: SW] : head;

    redmule_split_fifo #(
      .DW    (SW),
      .DEPTH (RESP_DEPTH)
    ) i_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push_i     (out_r_valid_i[ii]),
      .data_i     (out_r_data_i[ii*SW +: SW]),
      .pop_i      (fire),
      .empty_o    (empty[ii]),
      .head_o     (head),
      .overflow_o (ovf[ii])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gmask       <= '0;
      outstanding <= '0;
      err_o       <= 1'b0;
    end else begin
      gmask <= in_gnt_o ? '0 : (gmask | hit);
      if (|ovf) err_o <= 1'b1;
      case ({in_gnt_o, r_valid_p1})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   if (outstanding != '0) outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Stage p1: registered wide response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid_p1 <= 1'b0;
      r_data_p1  <= '0;
    end else begin
      r_valid_p1 <= fire;
      if (fire) r_data_p1 <= resp_data;
    end
  end

  assign in_r_valid_o = r_valid_p1;
  assign in_r_data_o  = r_data_p1;

endmodule
